// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
// Holds the loader FSM states and the frame length decode helper.
package mem_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    // Count byte to word count: zero means a full memory, larger values clamp.
    function automatic logic [8:0] frame_len(
        input logic [BYTE_W-1:0] count,
        input int                aw
    );
        logic [8:0] full;
        full = 9'(1 << aw);
        if (count == '0) begin
            return full;
        end
        if ({1'b0, count} > full) begin
            return full;
        end
        return {1'b0, count};
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Boot loader: framed byte stream in, 16-bit words out to program memory.
// Holds the CPU in reset until a frame lands with a matching checksum.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words
);

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BYTE_W-1:0]     hi_q;
    logic [BYTE_W-1:0]     sum_q;

    logic                  accept;
    logic                  launch;
    logic                  ready_next;
    logic                  sum_ok;
    logic [ADDR_WIDTH:0]   words_inc;
    logic [8:0]            len_full;

    assign accept    = in_valid && in_ready;
    assign words_inc = words + 1'b1;
    assign sum_ok    = (in_data == sum_q);
    assign len_full  = frame_len(in_data, ADDR_WIDTH);

    assign launch = start && (state == S_IDLE ||
                              state == S_DONE ||
                              state == S_ERROR);

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    state_next = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (words_inc == count_q) begin
                    state_next = S_CSUM;
                end else begin
                    state_next = S_HI;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = sum_ok ? S_DONE : S_ERROR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // in_ready is registered, so it is derived from the state being entered.
    always_comb begin
        ready_next = 1'b0;
        unique case (state_next)
            S_COUNT, S_HI, S_LO, S_CSUM: ready_next = 1'b1;
            default:                     ready_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            words    <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            hi_q     <= '0;
            sum_q    <= '0;
        end else begin
            in_ready <= ready_next;
            mem_we   <= 1'b0;
            if (launch) begin
                words    <= '0;
                addr_q   <= '0;
                busy     <= 1'b1;
                done     <= 1'b0;
                err      <= 1'b0;
                cpu_hold <= 1'b1;
            end
            unique case (state)
                S_COUNT: begin
                    if (accept) begin
                        count_q <= len_full[ADDR_WIDTH:0];
                        sum_q   <= in_data;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_q  <= in_data;
                        sum_q <= sum_q + in_data;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr_q;
                        mem_data <= {hi_q, in_data};
                        sum_q    <= sum_q + in_data;
                    end
                end
                S_WRITE: begin
                    addr_q <= addr_q + 1'b1;
                    words  <= words_inc;
                end
                S_CSUM: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (sum_ok) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: framed loads, checksum errors,
// full-range load, back-pressure and asynchronous reset mid-load.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  words;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [64];
    int          addr_log[$];
    int          cyc = 0;
    int          dbl_we = 0;
    int          we_ready = 0;
    logic        prev_we = 1'b0;

    mem_loader #(.ADDR_WIDTH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .words    (words)
    );

    always #5 clk = ~clk;

    // Program memory model plus write-port observers.
    always @(posedge clk) begin
        cyc++;
        if (mem_we) begin
            mem[mem_addr] = mem_data;
            addr_log.push_back(int'(mem_addr));
            if (in_ready) we_ready++;
        end
        if (mem_we && prev_we) dbl_we++;
        prev_we = mem_we;
    end

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: in_ready stuck %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] f[$], input bit gaps);
        foreach (f[i]) send_byte(f[i], gaps);
        in_valid = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({in_ready, busy, cpu_hold, done, err, words} !== {5'b11100, 7'd0}) begin
            errors++;
            $display("FAIL start_resp: rdy/busy/hold/done/err/words=%b%b%b%b%b/%0d want 11100/0",
                     in_ready, busy, cpu_hold, done, err, words);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, err, words}
            !== {1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
            errors++;
            $display("FAIL reset_vals: rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b w=%0d",
                     in_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, err, words);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_good_load();
        logic [7:0] fr[$];
        int base, c0;
        fr = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        base = addr_log.size();
        start_load();
        c0 = cyc;
        send_frame(fr, 1'b0);
        checks++;
        if (cyc - c0 != 8) begin
            errors++;
            $display("FAIL good_len: %0d cycles want 8", cyc - c0);
        end
        checks++;
        if (addr_log.size() - base != 2) begin
            errors++;
            $display("FAIL good_nwr: %0d writes want 2", addr_log.size() - base);
        end else begin
            checks++;
            if (addr_log[base] != 0 || addr_log[base+1] != 1) begin
                errors++;
                $display("FAIL good_addr: %0d,%0d want 0,1", addr_log[base], addr_log[base+1]);
            end
        end
        checks++;
        if (mem[0] !== 16'h1234 || mem[1] !== 16'hABCD) begin
            errors++;
            $display("FAIL good_mem: %h %h want 1234 abcd", mem[0], mem[1]);
        end
        checks++;
        if ({done, err, cpu_hold, busy, in_ready} !== 5'b10000 || words !== 7'd2) begin
            errors++;
            $display("FAIL good_status: done/err/hold/busy/rdy=%b%b%b%b%b w=%0d want 10000 w=2",
                     done, err, cpu_hold, busy, in_ready, words);
        end
        checks++;
        if (mem_addr !== 6'd1 || mem_data !== 16'hABCD || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL good_hold_bus: a=%h d=%h we=%b want 01 abcd 0", mem_addr, mem_data, mem_we);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] fr[$];
        int base;
        fr = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
        base = addr_log.size();
        start_load();
        send_frame(fr, 1'b0);
        checks++;
        if (addr_log.size() - base != 2) begin
            errors++;
            $display("FAIL bad_nwr: %0d writes want 2", addr_log.size() - base);
        end
        checks++;
        if ({done, err, cpu_hold, busy} !== 4'b0110 || words !== 7'd2) begin
            errors++;
            $display("FAIL bad_status: done/err/hold/busy=%b%b%b%b w=%0d want 0110 w=2",
                     done, err, cpu_hold, busy, words);
        end
        fr = {8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAC};
        start_load();
        send_frame(fr, 1'b0);
        checks++;
        if ({done, err, cpu_hold} !== 3'b100 || mem[0] !== 16'h1122 || mem[1] !== 16'h3344) begin
            errors++;
            $display("FAIL bad_retry: done/err/hold=%b%b%b mem=%h %h want 100 1122 3344",
                     done, err, cpu_hold, mem[0], mem[1]);
        end
    endtask

    task automatic test_full_range();
        logic [7:0] fr[$];
        logic [7:0] sum;
        logic [7:0] lo;
        int base, bad_a, bad_d;
        fr = {8'h00};
        sum = 8'h00;
        for (int i = 0; i < 64; i++) begin
            lo = ~8'(i);
            fr.push_back(8'(i));
            fr.push_back(lo);
            sum = sum + 8'(i) + lo;
        end
        checks++;
        if (sum !== 8'hC0) begin
            errors++;
            $display("FAIL full_sum_model: %h want c0", sum);
        end
        fr.push_back(sum);
        base = addr_log.size();
        start_load();
        send_frame(fr, 1'b0);
        checks++;
        if (addr_log.size() - base != 64) begin
            errors++;
            $display("FAIL full_nwr: %0d writes want 64", addr_log.size() - base);
        end else begin
            bad_a = 0;
            for (int i = 0; i < 64; i++) if (addr_log[base+i] != i) bad_a++;
            checks++;
            if (bad_a != 0) begin
                errors++;
                $display("FAIL full_addr: %0d bad addresses want 0", bad_a);
            end
        end
        bad_d = 0;
        for (int i = 0; i < 64; i++) begin
            lo = ~8'(i);
            if (mem[i] !== {8'(i), lo}) bad_d++;
        end
        checks++;
        if (bad_d != 0) begin
            errors++;
            $display("FAIL full_mem: %0d bad words want 0", bad_d);
        end
        checks++;
        if (words !== 7'd64 || done !== 1'b1 || mem_addr !== 6'd63) begin
            errors++;
            $display("FAIL full_status: w=%0d done=%b a=%0d want 64 1 63", words, done, mem_addr);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] fr[$];
        int base;
        fr = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
        base = addr_log.size();
        start_load();
        send_frame(fr, 1'b1);
        checks++;
        if (addr_log.size() - base != 2 || mem[0] !== 16'h1234 || mem[1] !== 16'hABCD) begin
            errors++;
            $display("FAIL bp_mem: n=%0d %h %h want 2 1234 abcd",
                     addr_log.size() - base, mem[0], mem[1]);
        end
        checks++;
        if (done !== 1'b1 || words !== 7'd2) begin
            errors++;
            $display("FAIL bp_status: done=%b w=%0d want 1 2", done, words);
        end
        checks++;
        if (we_ready != 0 || dbl_we != 0) begin
            errors++;
            $display("FAIL bp_write_cycle: ready_in_write=%0d long_we=%0d want 0 0", we_ready, dbl_we);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] fr[$];
        int base;
        base = addr_log.size();
        start_load();
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hAB, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (addr_log.size() - base != 1) begin
            errors++;
            $display("FAIL rst_mid_nwr: %0d writes want 1", addr_log.size() - base);
        end
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, err, words}
            !== {1'b0, 1'b0, 6'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
            errors++;
            $display("FAIL rst_mid_vals: rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b w=%0d",
                     in_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, err, words);
        end
        @(negedge clk);
        rst = 1'b0;
        fr = {8'h02, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h26};
        base = addr_log.size();
        start_load();
        send_frame(fr, 1'b0);
        checks++;
        if (addr_log.size() - base != 2 || addr_log[base] != 0) begin
            errors++;
            $display("FAIL rst_reload_addr: n=%0d first=%0d want 2 0",
                     addr_log.size() - base, addr_log[base]);
        end
        checks++;
        if (mem[0] !== 16'h5678 || mem[1] !== 16'h9ABC || done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL rst_reload: %h %h done=%b hold=%b want 5678 9abc 1 0",
                     mem[0], mem[1], done, cpu_hold);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_full_range();
        test_back_pressure();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
